// File: rtl/v8_pulse_gen.sv
// v8_pulse_gen: synthetic detector-pulse source for the v8 shaping-filter chain.
// Each accepted start produces a linear rise to the requested amplitude over 2^RiseShift
// cycles, followed by an exponential decay (acc -= acc >> TauShift). The pulse rides on a
// programmable baseline. A start during the decay piles up on top of the residual tail.
//
// Ports:
//   clk_i            sample clock
//   reset_i          synchronous, active-high reset
//   start_i          one-cycle pulse request
//   amplitude_i      pulse height in ADC counts, sampled with start_i
//   baseline_i       pedestal added to every sample, sampled continuously
//   ready_o          start_i will be accepted (not rising)
//   busy_o           a pulse is rising or decaying
//   peak_strobe_o    high in the cycle output_data_o shows the peak sample
//   start_dropped_o  one-cycle flag for a start_i that arrived while rising
//   output_data_o    generated ADC sample
module v8_pulse_gen #(
    parameter int unsigned SizeAdcData = 14,
    parameter int unsigned FracBits    = 8,
    parameter int unsigned TauShift    = 4,  // legal 1..8
    parameter int unsigned RiseShift   = 2   // legal 0..FracBits
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [SizeAdcData-1:0] amplitude_i,
    input  logic [SizeAdcData-1:0] baseline_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   peak_strobe_o,
    output logic                   start_dropped_o,
    output logic [SizeAdcData-1:0] output_data_o
);

    localparam int unsigned AccW = SizeAdcData + FracBits + 1;
    localparam int unsigned CntW = RiseShift + 1;

    // Largest representable pulse: full-scale integer part, zero fraction.
    localparam logic [AccW-1:0] AccMax =
        (AccW'(1) << (SizeAdcData + FracBits)) - (AccW'(1) << FracBits);
    localparam logic [AccW-1:0] OneCount = AccW'(1) << FracBits;
    localparam logic [AccW-1:0] AdcMaxW  = (AccW'(1) << SizeAdcData) - AccW'(1);
    localparam logic [CntW-1:0] RiseLast = CntW'((32'd1 << RiseShift) - 32'd1);

    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StDecay
    } state_e;

    state_e                 state_q, state_d;
    logic [AccW-1:0]        acc_q, acc_d;
    logic [AccW-1:0]        target_q, target_d;
    logic [AccW-1:0]        step_q, step_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   peak_q;
    logic                   dropped_q;
    logic [SizeAdcData-1:0] out_q, out_d;

    logic [AccW-1:0] amp_ext;
    logic [AccW-1:0] sum_start;
    logic [AccW-1:0] sum_step;
    logic [AccW-1:0] decay_next;
    logic [AccW-1:0] out_sum;
    logic            accept;

    assign amp_ext    = AccW'(amplitude_i) << FracBits;
    // Operands stay below 2^(AccW-1), so these sums cannot wrap before saturation.
    assign sum_start  = acc_q + amp_ext;
    assign sum_step   = acc_q + step_q;
    assign decay_next = acc_q - (acc_q >> TauShift);
    assign accept     = start_i && (state_q != StRise);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        target_d = target_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        pend_d   = 1'b0;

        if (accept) begin
            // Any decay update due this cycle is skipped; the rise starts from acc_q.
            target_d = (sum_start > AccMax) ? AccMax : sum_start;
            step_d   = amp_ext >> RiseShift;
            cnt_d    = '0;
            state_d  = StRise;
        end else begin
            unique case (state_q)
                StRise: begin
                    if (cnt_q == RiseLast) begin
                        // Land exactly on target to drop the step truncation error.
                        acc_d   = target_q;
                        state_d = StDecay;
                        pend_d  = 1'b1;
                    end else begin
                        acc_d = (sum_step > AccMax) ? AccMax : sum_step;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDecay: begin
                    if (decay_next < OneCount) begin
                        acc_d   = '0;
                        state_d = StIdle;
                    end else begin
                        acc_d = decay_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output sample uses the current accumulator, so it lags acc by one cycle.
    always_comb begin
        out_sum = AccW'(baseline_i) + (acc_q >> FracBits);
        out_d   = (out_sum > AdcMaxW) ? {SizeAdcData{1'b1}} : out_sum[SizeAdcData-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            target_q  <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            peak_q    <= 1'b0;
            dropped_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            target_q  <= target_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            // pend marks the last rise edge; the strobe follows one edge later so it
            // lines up with the peak sample on output_data_o.
            pend_q    <= pend_d;
            peak_q    <= pend_q;
            dropped_q <= start_i && (state_q == StRise);
            out_q     <= out_d;
        end
    end

    assign ready_o         = (state_q != StRise);
    assign busy_o          = (state_q != StIdle);
    assign peak_strobe_o   = peak_q;
    assign start_dropped_o = dropped_q;
    assign output_data_o   = out_q;

endmodule
